multi_switch_xor: RTL



---
 rtl/multi_switch_xor.sv | 105 ++++++++++
 1 files changed

// File: rtl/multi_switch_xor.sv
// ============================================================================
// Module      : multi_switch_xor
// Description : N-channel switch synchroniser and debouncer with a registered
//               parity output, a one-cycle parity-change pulse and an optional
//               saturating parity-change counter.
//               Optional feature macro: MULTI_SWITCH_XOR_CHGCNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_switch_xor #(
    parameter int N          = 2,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sw,
    output logic [N-1:0]     sw_db,
    output logic             f,
    output logic             f_chg,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam int c_DW = $clog2(DEB_CYCLES + 1);
    localparam logic [c_DW-1:0] c_LAST = c_DW'(DEB_CYCLES - 1);

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;
    logic [N-1:0] w_db;
    logic         w_par;
    logic         r_f;
    logic         r_f_chg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    // Each channel owns its counter and debounced bit; any agreement between
    // the synchronised level and the debounced level restarts the count.
    generate
        for (genvar i = 0; i < N; i++) begin : g_deb
            logic [c_DW-1:0] r_cnt;
            logic            r_db;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_s2[i] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_LAST) begin
                    r_db  <= r_s2[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_db[i] = r_db;
        end
    endgenerate

    assign w_par = ^w_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f     <= 1'b0;
            r_f_chg <= 1'b0;
        end else begin
            r_f     <= w_par;
            r_f_chg <= (w_par != r_f);
        end
    end

`ifdef MULTI_SWITCH_XOR_CHGCNT_EN
    logic [CNT_W-1:0] r_chg_cnt;

    // Counts on the same edge that registers the change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chg_cnt <= '0;
        end else if ((w_par != r_f) && (r_chg_cnt != {CNT_W{1'b1}})) begin
            r_chg_cnt <= r_chg_cnt + 1'b1;
        end
    end

    assign chg_cnt = r_chg_cnt;
`else
    assign chg_cnt = '0;
`endif

    assign sw_db = w_db;
    assign f     = r_f;
    assign f_chg = r_f_chg;

endmodule

`default_nettype wire
